y_vector_writer: RTL
====================

Name: y_vector_writer

Overview:
- Downstream consumer of the MAC intermediator's y-output path (push_to_y / v_to_y).
- Converts each finished 66-bit FloPoCo row result to IEEE-754 double and buffers it in a FIFO.
- Issues sequential 64-bit memory write requests starting at a programmed base address.
- Back-pressures the intermediator via stall_out.
- Signals completion once all results after eof are written.

Parameters:
FIFO_DEPTH, 64, entries in the result FIFO (power of two)
ALMOST_FULL_COUNT, 48, FIFO occupancy at or above which stall_out asserts
ADDR_WIDTH, 48, width of byte addresses

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: latch base_addr, clear counters, enter RUN
base_addr  input  ADDR_WIDTH  byte address of y[0]; must be 8-byte aligned
push_in  input  1  y value valid (from intermediator push_to_y)
v_in  input  66  FloPoCo value: [65:64] exn, [63] sign, [62:52] exp, [51:0] frac
eof  input  1  pulse: no push_in after this cycle (a push_in in the same cycle is accepted)
mem_stall  input  1  memory cannot take new requests
mem_req  output  1  write request valid
mem_addr  output  ADDR_WIDTH  write byte address
mem_data  output  64  IEEE double to write
stall_out  output  1  to intermediator stall_out
done  output  1  level: all results written, held until start or rst
count  output  32  number of write requests issued since start
error  output  1  sticky: push_in dropped (FIFO full or not in RUN)

Behaviour:
- Reset (rst=1 at a clock edge, at any time, including mid-drain):
  - state=IDLE; FIFO emptied.
  - mem_req=0, stall_out=0, done=0, count=0, error=0.
  - mem_addr/mem_data are don't-care while mem_req=0.
- States IDLE, RUN, DRAIN, DONE:
  - start in any state -> RUN. Flushes the FIFO and conversion register, clears count/error/done, latches base_addr.
  - start has priority over eof in the same cycle.
  - RUN + eof -> DRAIN.
  - DRAIN -> DONE when FIFO empty, conversion register empty and no pop in flight. done=1 from the cycle after the transition.
  - DONE -> RUN only on start.
- Conversion:
  - Stage 1 is a registered conversion; push_in at cycle t writes the FIFO at t+1.
  - Mapping by exn:
    - exn=00 -> {sign, 63'b0}
    - exn=01 -> {sign, exp, frac}
    - exn=10 -> {sign, 11'h7FF, 52'b0}
    - exn=11 -> 64'h7FF8000000000000
- Push acceptance:
  - Accepted only in RUN (including the eof cycle).
  - A push in IDLE/DRAIN/DONE is discarded and sets error.
  - A FIFO write while full is discarded and sets error; FIFO contents are unchanged.
- Pop and issue:
  - pop = state in {RUN, DRAIN} && !fifo_empty && !mem_stall.
  - mem_req is registered: mem_req(t+1) = pop(t), with mem_data = popped word.
  - mem_addr = base + 8*count, modulo 2^ADDR_WIDTH.
  - count increments with each issued request and wraps at 2^32.
  - The memory interface accepts the single request issued in the cycle after mem_stall rises.
- Simultaneous FIFO push and pop are both honoured; occupancy is unchanged.
- Throughput: one write per cycle when mem_stall=0.
- Latency: push_in to mem_req is 3 cycles (conversion, FIFO write, registered issue) for an empty FIFO.
- stall_out:
  - Registered: stall_out(t+1) = (occupancy(t) + conversion_valid(t) >= ALMOST_FULL_COUNT).
  - FIFO_DEPTH - ALMOST_FULL_COUNT (16) covers the intermediator's stall register plus its pipeline depth.
- done deasserts on the cycle after start.

Test Plan:
- Basic order: start with base_addr=0x1000, then 4 pushes of FloPoCo 1.0, 2.0, -3.5, 0 (exn 01/01/01/00), then eof -> mem_req on 4 consecutive cycles. Required: addresses 0x1000, 0x1008, 0x1010, 0x1018; data 0x3FF0000000000000, 0x4000000000000000, 0xC00C000000000000, 0x0; done=1 afterwards; count=4.
- Special values: exn=10 with sign=1 -> data 0xFFF0000000000000; exn=11 -> 0x7FF8000000000000; exn=00 with sign=1 -> 0x8000000000000000.
- Back-pressure: hold mem_stall=1 and push 60 values -> stall_out rises once occupancy ≥48 and error stays 0. Releasing mem_stall drains all 60 in order with contiguous addresses.
- Overflow and illegal push: with mem_stall=1, push 70 values ignoring stall_out -> error=1 and exactly 64 writes after release. A push in IDLE -> error=1 and no mem_req.
- Mid-operation control: rst asserted during DRAIN with 10 entries queued -> the next cycle has mem_req=0, done=0, count=0, with no further requests. Start during RUN with queued data -> FIFO flushed and addressing restarts at the new base.
- Same-cycle events: push_in and eof together -> value written and done follows. Start and eof together -> state RUN (not DRAIN). Address wrap with base=0xFFFFFFFFFFF8 and 2 pushes -> addresses 0xFFFFFFFFFFF8 then 0x0.

Source files
------------

// File: rtl/y_vector_writer.sv
// y_vector_writer
// Converts finished 66-bit FloPoCo row results to IEEE-754 doubles. Buffers them in
// a FIFO and writes them out as sequential 64-bit memory requests from a base address.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, base_addr   begin a new vector at base_addr (8-byte aligned)
//   push_in, v_in      FloPoCo result from the intermediator
//   eof                no further push_in after this cycle
//   mem_stall          memory cannot take a new request
//   mem_req/addr/data  registered write request
//   stall_out          back-pressure to the intermediator
//   done               all results of the vector written (level)
//   count              write requests issued since start
//   error              sticky: a push was dropped
module y_vector_writer #(
    parameter int FIFO_DEPTH        = 64,
    parameter int ALMOST_FULL_COUNT = 48,
    parameter int ADDR_WIDTH        = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  push_in,
    input  logic [65:0]           v_in,
    input  logic                  eof,
    input  logic                  mem_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_data,
    output logic                  stall_out,
    output logic                  done,
    output logic [31:0]           count,
    output logic                  error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  conv_valid_q, conv_valid_d;
    logic [63:0]           conv_data_q, conv_data_d;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           count_q, count_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]           mem_data_q, mem_data_d;
    logic                  stall_out_q, stall_out_d;
    logic                  error_q, error_d;

    logic [63:0]           fifo_mem [FIFO_DEPTH];

    logic [PTR_W:0]        occupancy;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  fifo_wr;

    function automatic logic [63:0] flopoco_to_double(input logic [65:0] v);
        logic [63:0] r;
        case (v[65:64])
            2'b00:   r = {v[63], 63'b0};
            2'b01:   r = v[63:0];
            2'b10:   r = {v[63], 11'h7FF, 52'b0};
            default: r = 64'h7FF8_0000_0000_0000;
        endcase
        return r;
    endfunction

    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == DEPTH_FULL);

    // start flushes everything, so neither a pop nor a FIFO write may happen in its cycle.
    assign pop     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty && !mem_stall && !start;
    assign fifo_wr = conv_valid_q && !fifo_full && !start;

    always_comb begin
        state_d      = state_q;
        conv_valid_d = push_in && (state_q == S_RUN);
        conv_data_d  = flopoco_to_double(v_in);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        base_d       = base_q;
        count_d      = count_q;
        mem_req_d    = pop;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        stall_out_d  = (int'(occupancy) + int'(conv_valid_q)) >= ALMOST_FULL_COUNT;
        error_d      = error_q
                     | (push_in && (state_q != S_RUN))
                     | (conv_valid_q && fifo_full);

        case (state_q)
            S_RUN:   if (eof) state_d = S_DRAIN;
            // mem_req_q low means the last popped word has been presented.
            S_DRAIN: if (fifo_empty && !conv_valid_q && !mem_req_q) state_d = S_DONE;
            default: ;
        endcase

        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            count_d    = count_q + 32'd1;
            mem_addr_d = base_q + ADDR_WIDTH'({count_q, 3'b000});
            mem_data_d = fifo_mem[rd_ptr_q[PTR_W-1:0]];
        end

        if (start) begin
            state_d      = S_RUN;
            conv_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            base_d       = base_addr;
            count_d      = '0;
            mem_req_d    = 1'b0;
            stall_out_d  = 1'b0;
            error_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            base_q       <= '0;
            count_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            stall_out_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_valid_q <= conv_valid_d;
            conv_data_q  <= conv_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            base_q       <= base_d;
            count_q      <= count_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            stall_out_q  <= stall_out_d;
            error_q      <= error_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= conv_data_q;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign stall_out = stall_out_q;
    assign done      = (state_q == S_DONE);
    assign count     = count_q;
    assign error     = error_q;

endmodule
